grid_move_engine: RTL

Sequential, parametrised successor to the combinational move translator. It holds the agent's current grid position in registers and accepts move commands over a valid/ready handshake. Before committing a move it queries an external wall/obstacle map. It records accepted moves in a bounded history stack so the maze-solver controller can backtrack with undo commands. It sits between the solver FSM (command side) and the maze map memory (query side).

---
 rtl/grid_move_engine.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/grid_move_engine.sv
// grid_move_engine
//   Holds the agent's grid position and executes move/undo commands received over a
//   valid/ready handshake. In-grid moves are checked against an external wall map before
//   being committed; committed moves are recorded in a circular history stack so the
//   solver can backtrack with undo commands.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_cmd_valid / o_cmd_ready  command handshake (ready only in idle)
//   i_cmd_op                   00 y-1, 01 x+1, 10 x-1, 11 y+1
//   i_cmd_undo                 pop history and reverse last move (op ignored)
//   o_blk_req, o_blk_x/y       wall query for the target cell, held until ack
//   i_blk_ack, i_blk_wall      query answer (wall valid with ack)
//   o_pos_x/y                  registered current position
//   o_done_valid/status        one-cycle completion pulse: 00 MOVED 01 EDGE 10 WALL 11 EMPTY
//   o_hist_count               number of valid history entries
module grid_move_engine #(
  parameter int unsigned COORD_W    = 4,
  parameter int unsigned START_X    = 0,
  parameter int unsigned START_Y    = 0,
  parameter int unsigned WRAP       = 0,
  parameter int unsigned HIST_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic [1:0]                    i_cmd_op,
  input  logic                          i_cmd_undo,
  output logic                          o_blk_req,
  output logic [COORD_W-1:0]            o_blk_x,
  output logic [COORD_W-1:0]            o_blk_y,
  input  logic                          i_blk_ack,
  input  logic                          i_blk_wall,
  output logic [COORD_W-1:0]            o_pos_x,
  output logic [COORD_W-1:0]            o_pos_y,
  output logic                          o_done_valid,
  output logic [1:0]                    o_done_status,
  output logic [$clog2(HIST_DEPTH):0]   o_hist_count
);

  localparam int unsigned PTR_W = $clog2(HIST_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] OpUp    = 2'b00;
  localparam logic [1:0] OpRight = 2'b01;
  localparam logic [1:0] OpLeft  = 2'b10;
  localparam logic [1:0] OpDown  = 2'b11;

  localparam logic [1:0] StatusMoved = 2'b00;
  localparam logic [1:0] StatusEdge  = 2'b01;
  localparam logic [1:0] StatusWall  = 2'b10;
  localparam logic [1:0] StatusEmpty = 2'b11;

  localparam logic [COORD_W-1:0] CoordMax = '1;

  typedef enum logic [1:0] {StIdle, StCheck, StResolve} state_e;

  state_e               r_state, w_state_nxt;
  logic [COORD_W-1:0]   r_pos_x, r_pos_y, w_pos_x_nxt, w_pos_y_nxt;
  logic [COORD_W-1:0]   r_tgt_x, r_tgt_y, w_tgt_x_nxt, w_tgt_y_nxt;
  logic [1:0]           r_op, w_op_nxt;
  logic [1:0]           r_status, w_status_nxt;
  logic [PTR_W-1:0]     r_top, w_top_nxt;
  logic [CNT_W-1:0]     r_count, w_count_nxt;
  logic [1:0]           r_hist [HIST_DEPTH];
  logic                 w_push;

  logic [COORD_W-1:0]   w_mv_x, w_mv_y, w_un_x, w_un_y;
  logic [1:0]           w_pop_op;
  logic                 w_edge;

  // Coordinate arithmetic is modulo 2^COORD_W; saturate mode relies on w_edge instead.
  function automatic logic [COORD_W-1:0] step_x(input logic [COORD_W-1:0] x,
                                                input logic [1:0] op);
    unique case (op)
      OpRight: return x + COORD_W'(1);
      OpLeft:  return x - COORD_W'(1);
      default: return x;
    endcase
  endfunction

  function automatic logic [COORD_W-1:0] step_y(input logic [COORD_W-1:0] y,
                                                input logic [1:0] op);
    unique case (op)
      OpUp:    return y - COORD_W'(1);
      OpDown:  return y + COORD_W'(1);
      default: return y;
    endcase
  endfunction

  assign w_mv_x   = step_x(r_pos_x, i_cmd_op);
  assign w_mv_y   = step_y(r_pos_y, i_cmd_op);
  assign w_pop_op = r_hist[r_top - PTR_W'(1)];
  // Bitwise inversion maps each op onto its opposite direction (00<->11, 01<->10).
  assign w_un_x   = step_x(r_pos_x, ~w_pop_op);
  assign w_un_y   = step_y(r_pos_y, ~w_pop_op);

  assign w_edge = (WRAP == 0) &&
                  (((i_cmd_op == OpUp)    && (r_pos_y == '0))      ||
                   ((i_cmd_op == OpRight) && (r_pos_x == CoordMax)) ||
                   ((i_cmd_op == OpLeft)  && (r_pos_x == '0))      ||
                   ((i_cmd_op == OpDown)  && (r_pos_y == CoordMax)));

  always_comb begin
    w_state_nxt  = r_state;
    w_pos_x_nxt  = r_pos_x;
    w_pos_y_nxt  = r_pos_y;
    w_tgt_x_nxt  = r_tgt_x;
    w_tgt_y_nxt  = r_tgt_y;
    w_op_nxt     = r_op;
    w_status_nxt = r_status;
    w_top_nxt    = r_top;
    w_count_nxt  = r_count;
    w_push       = 1'b0;
    o_cmd_ready  = 1'b0;
    o_blk_req    = 1'b0;
    o_done_valid = 1'b0;

    unique case (r_state)
      StIdle: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_op_nxt    = i_cmd_op;
          w_tgt_x_nxt = w_mv_x;
          w_tgt_y_nxt = w_mv_y;
          if (i_cmd_undo) begin
            w_state_nxt = StResolve;
            if (r_count == '0) begin
              w_status_nxt = StatusEmpty;
            end else begin
              // The reversed path was walked before, so no wall or edge check is needed.
              w_pos_x_nxt  = w_un_x;
              w_pos_y_nxt  = w_un_y;
              w_top_nxt    = r_top - PTR_W'(1);
              w_count_nxt  = r_count - CNT_W'(1);
              w_status_nxt = StatusMoved;
            end
          end else if (w_edge) begin
            w_state_nxt  = StResolve;
            w_status_nxt = StatusEdge;
          end else begin
            w_state_nxt = StCheck;
          end
        end
      end
      StCheck: begin
        o_blk_req = 1'b1;
        if (i_blk_ack) begin
          w_state_nxt = StResolve;
          if (i_blk_wall) begin
            w_status_nxt = StatusWall;
          end else begin
            w_pos_x_nxt  = r_tgt_x;
            w_pos_y_nxt  = r_tgt_y;
            w_push       = 1'b1;
            w_top_nxt    = r_top + PTR_W'(1);
            // When full the write slot is the oldest entry, so only the count saturates.
            if (r_count != CNT_W'(HIST_DEPTH)) begin
              w_count_nxt = r_count + CNT_W'(1);
            end
            w_status_nxt = StatusMoved;
          end
        end
      end
      StResolve: begin
        o_done_valid = 1'b1;
        w_state_nxt  = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_pos_x  <= COORD_W'(START_X);
      r_pos_y  <= COORD_W'(START_Y);
      r_tgt_x  <= '0;
      r_tgt_y  <= '0;
      r_op     <= '0;
      r_status <= StatusMoved;
      r_top    <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(HIST_DEPTH); i++) begin
        r_hist[i] <= '0;
      end
    end else begin
      r_state  <= w_state_nxt;
      r_pos_x  <= w_pos_x_nxt;
      r_pos_y  <= w_pos_y_nxt;
      r_tgt_x  <= w_tgt_x_nxt;
      r_tgt_y  <= w_tgt_y_nxt;
      r_op     <= w_op_nxt;
      r_status <= w_status_nxt;
      r_top    <= w_top_nxt;
      r_count  <= w_count_nxt;
      if (w_push) begin
        r_hist[r_top] <= r_op;
      end
    end
  end

  assign o_blk_x       = r_tgt_x;
  assign o_blk_y       = r_tgt_y;
  assign o_pos_x       = r_pos_x;
  assign o_pos_y       = r_pos_y;
  assign o_done_status = r_status;
  assign o_hist_count  = r_count;

endmodule
